// File: rtl/input_ctrl.sv
// Execute-key front end: synchronizes and debounces KEYb, latches SW as the instruction
// and handshakes with the controller. Define INPUT_TIMEOUT_EN to abort a missing DONE.
module input_ctrl #(
    parameter int DEB_CYCLES = 16,
    parameter int TIMEOUT    = 1024
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic [9:0] SW,
    input  logic       KEYb,
    input  logic       DONE,
    output logic [9:0] INSTR,
    output logic       EXEC,
    output logic       BUSY,
    output logic       ERR
);

    localparam int DEB_W = $clog2(DEB_CYCLES);
    localparam logic [DEB_W-1:0] DEB_LAST = DEB_W'(DEB_CYCLES - 1);

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_ARM     = 2'd1;
    localparam logic [1:0] ST_WAIT    = 2'd2;
    localparam logic [1:0] ST_RELEASE = 2'd3;

    logic [1:0]       sync_reg;
    logic [1:0]       vld_reg;
    logic             armed_reg;
    logic             deb_reg;
    logic             deb_prev_reg;
    logic [DEB_W-1:0] deb_cnt_reg;
    logic             key_sync;
    logic             press;

    logic [1:0]       state_reg;
    logic [9:0]       instr_reg;
    logic             exec_reg;
    logic             busy_reg;

    assign key_sync = sync_reg[1];

    // armed_reg keeps a key held through reset from firing: a released sample must be
    // seen once the synchronizer holds real data again (vld_reg[1]).
    assign press = deb_prev_reg & ~deb_reg & armed_reg;

    always_ff @(posedge CLK) begin
        if (RST) begin
            sync_reg     <= 2'b11;
            vld_reg      <= 2'b00;
            armed_reg    <= 1'b0;
            deb_reg      <= 1'b1;
            deb_prev_reg <= 1'b1;
            deb_cnt_reg  <= '0;
        end else begin
            sync_reg     <= {sync_reg[0], KEYb};
            vld_reg      <= {vld_reg[0], 1'b1};
            deb_prev_reg <= deb_reg;
            if (vld_reg[1] && key_sync) begin
                armed_reg <= 1'b1;
            end
            if (key_sync != deb_reg) begin
                if (deb_cnt_reg == DEB_LAST) begin
                    deb_reg     <= key_sync;
                    deb_cnt_reg <= '0;
                end else begin
                    deb_cnt_reg <= deb_cnt_reg + 1'b1;
                end
            end else begin
                deb_cnt_reg <= '0;
            end
        end
    end

`ifdef INPUT_TIMEOUT_EN
    localparam int TMO_W = $clog2(TIMEOUT + 1);
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT - 1);

    logic [TMO_W-1:0] tmo_cnt_reg;
    logic             err_reg;

    assign ERR = err_reg;
`else
    logic unused_timeout_cfg;

    assign unused_timeout_cfg = (TIMEOUT > 0);
    assign ERR                = 1'b0;
`endif

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_reg   <= ST_IDLE;
            instr_reg   <= '0;
            exec_reg    <= 1'b0;
            busy_reg    <= 1'b0;
`ifdef INPUT_TIMEOUT_EN
            tmo_cnt_reg <= '0;
            err_reg     <= 1'b0;
`endif
        end else begin
            exec_reg <= 1'b0;
`ifdef INPUT_TIMEOUT_EN
            err_reg  <= 1'b0;
`endif
            case (state_reg)
                ST_IDLE: begin
                    if (press) begin
                        state_reg <= ST_ARM;
                        instr_reg <= SW;
                        busy_reg  <= 1'b1;
                        exec_reg  <= 1'b1;
                    end
                end
                ST_ARM: begin
`ifdef INPUT_TIMEOUT_EN
                    tmo_cnt_reg <= '0;
`endif
                    state_reg <= DONE ? ST_RELEASE : ST_WAIT;
                end
                ST_WAIT: begin
                    if (DONE) begin
                        state_reg <= ST_RELEASE;
`ifdef INPUT_TIMEOUT_EN
                    end else if (tmo_cnt_reg == TMO_LAST) begin
                        state_reg <= ST_RELEASE;
                        err_reg   <= 1'b1;
                    end else begin
                        tmo_cnt_reg <= tmo_cnt_reg + 1'b1;
`endif
                    end
                end
                ST_RELEASE: begin
                    if (deb_reg) begin
                        state_reg <= ST_IDLE;
                        busy_reg  <= 1'b0;
                    end
                end
                default: begin
                    state_reg <= ST_IDLE;
                end
            endcase
        end
    end

    assign INSTR = instr_reg;
    assign EXEC  = exec_reg;
    assign BUSY  = busy_reg;

endmodule

// File: tb/tb_input_ctrl.sv
// Bench for input_ctrl: directed sequences and a vector table, with every cycle also
// compared against an edge-indexed reference model built from sample history.
module tb_input_ctrl;

    localparam int DEB = 16;
    localparam int TMO = 8;
`ifdef INPUT_TIMEOUT_EN
    localparam bit TMO_EN = 1'b1;
`else
    localparam bit TMO_EN = 1'b0;
`endif
    localparam int BIG = 1 << 30;

    logic       CLK = 1'b0;
    logic       RST = 1'b1;
    logic [9:0] SW = '0;
    logic       KEYb = 1'b1;
    logic       DONE = 1'b0;
    logic [9:0] INSTR;
    logic       EXEC;
    logic       BUSY;
    logic       ERR;

    input_ctrl #(.DEB_CYCLES(DEB), .TIMEOUT(TMO)) dut (
        .CLK(CLK), .RST(RST), .SW(SW), .KEYb(KEYb), .DONE(DONE),
        .INSTR(INSTR), .EXEC(EXEC), .BUSY(BUSY), .ERR(ERR)
    );

    always #5 CLK = ~CLK;

    int total = 0;
    int bad = 0;
    int exec_seen = 0;
    int err_seen = 0;
    int err_total = 0;

    // Reference model: raw key samples indexed by edge number.
    bit         raw_q[$];
    int         n = 0;
    int         reset_edge = -BIG;
    int         first_high = BIG;
    int         fell_at = -BIG;
    bit         m_deb = 1'b1;
    bit         m_busy = 1'b0;
    bit         m_got_done = 1'b0;
    int         m_acc = 0;
    logic [9:0] m_instr = '0;
    bit         m_exec = 1'b0;
    bit         m_err = 1'b0;
    bit         model_valid = 1'b0;

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s edge=%0d actual=%0d required=%0d", name, n, act, exp);
        end
    endtask

    function automatic bit synced_at(input int j);
        if (j - 2 <= reset_edge) return 1'b1;
        return raw_q[j-2];
    endfunction

    task automatic model_step(input bit rst, input bit key, input logic [9:0] sw, input bit done);
        bit deb_b;
        bit press;
        bit flip;
        raw_q.push_back(key);
        if (rst) begin
            reset_edge  = n;
            first_high  = BIG;
            fell_at     = -BIG;
            m_deb       = 1'b1;
            m_busy      = 1'b0;
            m_got_done  = 1'b0;
            m_instr     = '0;
            m_exec      = 1'b0;
            m_err       = 1'b0;
            model_valid = 1'b1;
        end else begin
            deb_b = m_deb;
            press = (fell_at == n - 1) && (first_high <= n - 3);
            // The level flips once DEB consecutive post-reset samples all disagree with it.
            flip = 1'b1;
            for (int j = n - DEB + 1; j <= n; j++) begin
                if (j <= reset_edge || synced_at(j) == deb_b) flip = 1'b0;
            end
            if (flip) begin
                m_deb = ~deb_b;
                if (deb_b) fell_at = n;
            end
            if (key && first_high == BIG) first_high = n;
            m_exec = 1'b0;
            m_err  = 1'b0;
            if (!m_busy) begin
                if (press) begin
                    m_busy     = 1'b1;
                    m_instr    = sw;
                    m_acc      = n;
                    m_got_done = 1'b0;
                    m_exec     = 1'b1;
                end
            end else if (!m_got_done) begin
                if (done) begin
                    m_got_done = 1'b1;
                end else if (TMO_EN && (n - m_acc == TMO + 1)) begin
                    m_got_done = 1'b1;
                    m_err      = 1'b1;
                end
            end else if (deb_b) begin
                m_busy = 1'b0;
            end
        end
        n++;
    endtask

    task automatic tick();
        @(posedge CLK);
        model_step(RST, KEYb, SW, DONE);
        @(negedge CLK);
        if (model_valid) begin
            check("model_exec", int'(EXEC), int'(m_exec));
            check("model_busy", int'(BUSY), int'(m_busy));
            check("model_instr", int'(INSTR), int'(m_instr));
            check("model_err", int'(ERR), int'(m_err));
        end
        if (EXEC === 1'b1) exec_seen++;
        if (ERR === 1'b1) begin
            err_seen++;
            err_total++;
        end
    endtask

    task automatic run(input int k);
        repeat (k) tick();
    endtask

    // Holds the key low and returns how many ticks until EXEC shows (0 if never).
    task automatic press_until_exec(output int lat);
        lat = 0;
        KEYb = 1'b0;
        for (int i = 1; i <= 60 && lat == 0; i++) begin
            tick();
            if (EXEC === 1'b1) lat = i;
        end
    endtask

    typedef struct {
        int         low_len;
        logic [9:0] sw;
        int         exp_execs;
    } vec_t;

    vec_t vecs[7];

    initial begin
        #5_000_000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat;
        vecs[0] = '{1,  10'h111, 0};
        vecs[1] = '{5,  10'h122, 0};
        vecs[2] = '{15, 10'h133, 0};
        vecs[3] = '{16, 10'h3C3, 1};
        vecs[4] = '{40, 10'h2A5, 1};
        vecs[5] = '{17, 10'h0AB, 1};
        vecs[6] = '{2,  10'h155, 0};

        // Reset with the key held and switches all ones.
        RST = 1'b1; KEYb = 1'b0; SW = 10'h3FF;
        run(3);
        check("rst_instr", int'(INSTR), 0);
        check("rst_exec", int'(EXEC), 0);
        check("rst_busy", int'(BUSY), 0);
        check("rst_err", int'(ERR), 0);
        RST = 1'b0;
        exec_seen = 0;
        run(40);
        check("held_after_rst_exec", exec_seen, 0);
        KEYb = 1'b1;
        run(30);
        check("release_after_rst_exec", exec_seen, 0);

        // Basic press latency and pulse width.
        SW = 10'h2A5;
        press_until_exec(lat);
        check("press_latency", lat, DEB + 3);
        check("press_instr", int'(INSTR), 10'h2A5);
        check("press_busy", int'(BUSY), 1);
        tick();
        check("exec_width", int'(EXEC), 0);

        // Handshake: SW changes, key bounces back down while waiting, DONE arrives.
        SW = 10'h001;
        exec_seen = 0;
        run(5);
        KEYb = 1'b1;
        run(5);
        KEYb = 1'b0;
        run(6);
        DONE = 1'b1;
        tick();
        DONE = 1'b0;
        run(10);
        check("hs_instr_hold", int'(INSTR), 10'h2A5);
        check("hs_busy_held", int'(BUSY), 1);
        check("hs_no_second_exec", exec_seen, 0);
        KEYb = 1'b1;
        lat = 0;
        for (int i = 1; i <= 60 && lat == 0; i++) begin
            tick();
            if (BUSY === 1'b0) lat = i;
        end
        check("busy_drop_latency", lat, DEB + 3);
        run(5);

        // Table of press lengths, including the shortest accepted press.
        for (int v = 0; v < 7; v++) begin
            SW = vecs[v].sw;
            exec_seen = 0;
            KEYb = 1'b0;
            run(vecs[v].low_len);
            KEYb = 1'b1;
            run(5);
            SW = vecs[v].sw ^ 10'h3FF;
            run(20);
            DONE = 1'b1;
            tick();
            DONE = 1'b0;
            run(25);
            check("vec_execs", exec_seen, vecs[v].exp_execs);
            if (vecs[v].exp_execs > 0) check("vec_instr", int'(INSTR), int'(vecs[v].sw));
            check("vec_idle_busy", int'(BUSY), 0);
        end

        // Reset while waiting for DONE, then a stray DONE.
        SW = 10'h3C3;
        press_until_exec(lat);
        check("midrst_press_seen", int'(lat != 0), 1);
        run(2);
        RST = 1'b1;
        tick();
        RST = 1'b0;
        check("midrst_instr", int'(INSTR), 0);
        check("midrst_busy", int'(BUSY), 0);
        check("midrst_exec", int'(EXEC), 0);
        DONE = 1'b1;
        tick();
        DONE = 1'b0;
        check("stray_done_busy", int'(BUSY), 0);
        check("stray_done_instr", int'(INSTR), 0);
        exec_seen = 0;
        run(30);
        check("held_after_midrst_exec", exec_seen, 0);
        KEYb = 1'b1;
        run(30);

`ifdef INPUT_TIMEOUT_EN
        // Timeout fires TMO cycles into WAIT_DONE.
        SW = 10'h0F0;
        press_until_exec(lat);
        lat = 0;
        for (int i = 1; i <= 40 && lat == 0; i++) begin
            tick();
            if (ERR === 1'b1) lat = i;
        end
        check("timeout_latency", lat, TMO + 1);
        tick();
        check("err_width", int'(ERR), 0);
        KEYb = 1'b1;
        run(40);
        check("timeout_idle_busy", int'(BUSY), 0);

        // DONE on the timeout edge wins.
        press_until_exec(lat);
        err_seen = 0;
        run(TMO);
        DONE = 1'b1;
        tick();
        DONE = 1'b0;
        run(5);
        check("done_beats_timeout_err", err_seen, 0);
        check("done_beats_timeout_busy", int'(BUSY), 1);
        KEYb = 1'b1;
        run(40);
`endif

        // Random stimulus against the model.
        for (int s = 0; s < 300; s++) begin
            int len;
            KEYb = 1'($urandom_range(0, 1));
            len = $urandom_range(1, 40);
            for (int c = 0; c < len; c++) begin
                SW   = 10'($urandom);
                DONE = ($urandom_range(0, 15) == 0);
                RST  = ($urandom_range(0, 299) == 0);
                tick();
            end
        end
        RST = 1'b0; DONE = 1'b0; KEYb = 1'b1;
        run(60);

`ifndef INPUT_TIMEOUT_EN
        check("err_never_without_timeout", err_total, 0);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
